// File: rtl/c_output_writer_if.sv
// Handshake bundle between controller, processor, C memory and the
// per-processor output writer.
interface c_output_writer_if #(
  parameter int N                            = 4,
  parameter int PARALLEL_DATA_STREAMING_SIZE = 4,
  parameter int OUT_WIDTH                    = 32,
  parameter int MEMORY_ADDRESS_BITS          = 64,
  parameter int LEN_BITS                     = 13
);
  logic                           c_address_valid;
  logic                           c_address_ready;
  logic [MEMORY_ADDRESS_BITS-1:0] c_address_input;
  logic [LEN_BITS-1:0]            matrix_length_input;
  logic                           proc_valid;
  logic                           proc_ready;
  logic [OUT_WIDTH-1:0]           proc_data [N];
  logic                           mem_write_valid;
  logic                           mem_write_ready;
  logic [MEMORY_ADDRESS_BITS-1:0] mem_write_addr;
  logic [OUT_WIDTH-1:0]           mem_write_data [PARALLEL_DATA_STREAMING_SIZE];
  logic                           tile_done;

  modport master (
    output c_address_valid, c_address_input, matrix_length_input,
    output proc_valid, proc_data, mem_write_ready,
    input  c_address_ready, proc_ready, mem_write_valid,
    input  mem_write_addr, mem_write_data, tile_done
  );

  modport slave (
    input  c_address_valid, c_address_input, matrix_length_input,
    input  proc_valid, proc_data, mem_write_ready,
    output c_address_ready, proc_ready, mem_write_valid,
    output mem_write_addr, mem_write_data, tile_done
  );
endinterface

// File: rtl/c_output_writer.sv
// Per-processor C tile writer: latches a tile base/stride, takes N result
// rows and streams each row to memory in P-element beats.
module c_output_writer #(
  parameter int DATA_WIDTH                   = 8,
  parameter int N                            = 4,
  parameter int MEMORY_ADDRESS_BITS          = 64,
  parameter int PARALLEL_DATA_STREAMING_SIZE = 4,
  parameter int MAX_MATRIX_LENGTH            = 4096,
  parameter int MULTIPLY_DATA_WIDTH          = 2*DATA_WIDTH,
  parameter int ACCUM_DATA_WIDTH             = 16,
  parameter int OUT_WIDTH                    = MULTIPLY_DATA_WIDTH+ACCUM_DATA_WIDTH,
  parameter int ELEM_BYTES                   = OUT_WIDTH/8
) (
  input logic             clk,
  input logic             reset,
  c_output_writer_if.slave bus
);
  localparam int P      = PARALLEL_DATA_STREAMING_SIZE;
  localparam int AW     = MEMORY_ADDRESS_BITS;
  localparam int BEATS  = N / P;
  localparam int ROW_W  = (N > 1) ? $clog2(N) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LEN_W  = $clog2(MAX_MATRIX_LENGTH+1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ROW = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [AW-1:0]        r_base;
  logic [AW-1:0]        r_stride;
  logic [ROW_W-1:0]     r_row;
  logic [BEAT_W-1:0]    r_beat;
  logic [OUT_WIDTH-1:0] r_rowbuf [N];
  logic                 r_done;

  logic                 w_addr_hs;
  logic                 w_row_hs;
  logic                 w_beat_hs;
  logic                 w_last_beat;
  logic                 w_last_row;
  logic [LEN_W-1:0]     w_len;
  logic [AW-1:0]        w_row_off;
  logic [AW-1:0]        w_beat_off;
  logic [OUT_WIDTH-1:0] w_data [P];

  assign w_len       = bus.matrix_length_input;
  assign w_addr_hs   = bus.c_address_valid && (r_state == S_IDLE);
  assign w_row_hs    = bus.proc_valid && (r_state == S_WAIT_ROW);
  assign w_beat_hs   = bus.mem_write_ready && (r_state == S_WRITE);
  assign w_last_beat = (r_beat == BEAT_W'(BEATS-1));
  assign w_last_row  = (r_row == ROW_W'(N-1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: idle -> wait row -> write beats -> next row or idle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (w_addr_hs) w_next = S_WAIT_ROW;
      S_WAIT_ROW: if (w_row_hs)  w_next = S_WRITE;
      S_WRITE: begin
        if (w_beat_hs && w_last_beat)
          w_next = w_last_row ? S_IDLE : S_WAIT_ROW;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  // Latch tile base and byte stride of one C row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base   <= '0;
      r_stride <= '0;
    end else if (w_addr_hs) begin
      r_base   <= bus.c_address_input;
      r_stride <= AW'(w_len) * AW'(ELEM_BYTES);
    end
  end

  // Row and beat counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row  <= '0;
      r_beat <= '0;
    end else if (w_addr_hs) begin
      r_row  <= '0;
      r_beat <= '0;
    end else if (w_beat_hs) begin
      if (w_last_beat) begin
        r_beat <= '0;
        if (!w_last_row) r_row <= r_row + 1'b1;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Capture one result row from the processor
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_rowbuf[i] <= '0;
    end else if (w_row_hs) begin
      for (int i = 0; i < N; i++) r_rowbuf[i] <= bus.proc_data[i];
    end
  end

  // Completion pulse one cycle after the final beat is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_beat_hs && w_last_beat && w_last_row;
  end

  assign w_row_off  = AW'(r_row) * r_stride;
  assign w_beat_off = AW'(r_beat) * AW'(P*ELEM_BYTES);

  // Select the P elements of the current beat; zero when not writing
  always_comb begin
    for (int k = 0; k < P; k++) begin
      w_data[k] = '0;
      if (r_state == S_WRITE) begin
        for (int b = 0; b < BEATS; b++)
          if (r_beat == BEAT_W'(b)) w_data[k] = r_rowbuf[b*P+k];
      end
    end
  end

  assign bus.c_address_ready = (r_state == S_IDLE);
  assign bus.proc_ready      = (r_state == S_WAIT_ROW);
  assign bus.mem_write_valid = (r_state == S_WRITE);
  assign bus.mem_write_addr  = (r_state == S_WRITE) ?
                               (r_base + w_row_off + w_beat_off) : '0;
  assign bus.mem_write_data  = w_data;
  assign bus.tile_done       = r_done;
endmodule

// File: tb/tb_c_output_writer.sv
// Directed bench for c_output_writer: P=4 instance for the main tile
// scenarios plus a P=2 instance for the multi-beat row split.
module tb_c_output_writer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  c_output_writer_if #(
    .N(4), .PARALLEL_DATA_STREAMING_SIZE(4), .OUT_WIDTH(32),
    .MEMORY_ADDRESS_BITS(64), .LEN_BITS(13)
  ) bus ();

  c_output_writer_if #(
    .N(4), .PARALLEL_DATA_STREAMING_SIZE(2), .OUT_WIDTH(32),
    .MEMORY_ADDRESS_BITS(64), .LEN_BITS(13)
  ) bus2 ();

  c_output_writer #(
    .N(4), .PARALLEL_DATA_STREAMING_SIZE(4)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  c_output_writer #(
    .N(4), .PARALLEL_DATA_STREAMING_SIZE(2)
  ) dut2 (
    .clk(clk), .reset(rst), .bus(bus2)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0]  q_addr [$];
  logic [127:0] q_data [$];
  int done_cnt;
  int done_lat;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [127:0] exp_row(input int r);
    return {32'(r*4+3), 32'(r*4+2), 32'(r*4+1), 32'(r*4)};
  endfunction

  function automatic logic [127:0] pk();
    return {bus.mem_write_data[3], bus.mem_write_data[2],
            bus.mem_write_data[1], bus.mem_write_data[0]};
  endfunction

  function automatic logic [63:0] qa(input int i);
    return (i < q_addr.size()) ? q_addr[i] : '1;
  endfunction

  function automatic logic [127:0] qd(input int i);
    return (i < q_data.size()) ? q_data[i] : '1;
  endfunction

  task automatic run_tile(input logic [63:0] base, input logic [12:0] len,
                          input bit skip_addr, input int stall_beat,
                          input int stall_n, input logic [63:0] inj_addr,
                          input int abort_after);
    int  pr, hs_k, done_k, stall_left, post_wr;
    bit  adr_hs, row_hs, inj_pend, inj_done;
    q_addr.delete();
    q_data.delete();
    done_cnt = 0; done_lat = -1;
    pr = 0; hs_k = -1; done_k = -1; post_wr = 0;
    stall_left = stall_n; inj_pend = 0; inj_done = 0;
    if (!skip_addr) begin
      bus.c_address_valid     = 1'b1;
      bus.c_address_input     = base;
      bus.matrix_length_input = len;
    end
    for (int k = 0; k < 120; k++) begin
      if (abort_after > 0 && q_addr.size() == abort_after) begin
        rst = 1'b1;
        #1;
        chk("rst_c_rdy", 128'(bus.c_address_ready), 128'(1));
        chk("rst_p_rdy", 128'(bus.proc_ready), 128'(0));
        chk("rst_w_vld", 128'(bus.mem_write_valid), 128'(0));
        chk("rst_addr", 128'(bus.mem_write_addr), 128'(0));
        chk("rst_data", pk(), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.c_address_valid = 1'b0;
        bus.mem_write_ready = 1'b1;
        repeat (20) begin
          if (bus.tile_done) done_cnt++;
          if (bus.mem_write_valid) post_wr++;
          @(posedge clk); #1;
        end
        chk("rst_no_done", 128'(done_cnt), 128'(0));
        chk("rst_no_wr", 128'(post_wr), 128'(0));
        return;
      end
      bus.proc_valid = (pr < 4);
      for (int c = 0; c < 4; c++) bus.proc_data[c] = 32'(pr*4+c);
      if (inj_addr != '0 && pr >= 1 && !inj_pend && !inj_done) begin
        inj_pend = 1'b1;
        bus.c_address_valid     = 1'b1;
        bus.c_address_input     = inj_addr;
        bus.matrix_length_input = 13'd8;
        chk("busy_c_rdy", 128'(bus.c_address_ready), 128'(0));
      end
      if (stall_left > 0 && bus.mem_write_valid &&
          q_addr.size() == stall_beat) begin
        bus.mem_write_ready = 1'b0;
        chk("bp_addr", 128'(bus.mem_write_addr),
            128'(base + 64'(stall_beat) * 64'(len) * 64'd4));
        chk("bp_data", pk(), exp_row(stall_beat));
        chk("bp_p_rdy", 128'(bus.proc_ready), 128'(0));
        stall_left--;
      end else begin
        bus.mem_write_ready = 1'b1;
      end
      adr_hs = bus.c_address_valid && bus.c_address_ready;
      row_hs = bus.proc_valid && bus.proc_ready;
      if (bus.mem_write_valid && bus.mem_write_ready) begin
        q_addr.push_back(bus.mem_write_addr);
        q_data.push_back(pk());
      end
      if (bus.tile_done) begin
        done_cnt++;
        done_k = k;
      end
      if (adr_hs && inj_pend)
        chk("inj_at_done", 128'(bus.tile_done), 128'(1));
      @(posedge clk); #1;
      if (adr_hs) begin
        bus.c_address_valid = 1'b0;
        if (inj_pend) begin
          inj_pend = 1'b0;
          inj_done = 1'b1;
        end else begin
          hs_k = k;
        end
      end
      if (row_hs) pr++;
      if (done_k >= 0 && k >= done_k + 2) break;
    end
    if (hs_k >= 0 && done_k >= 0) done_lat = done_k - hs_k;
    bus.proc_valid = 1'b0;
  endtask

  task automatic run_p2();
    int pr, dc;
    bit ahs, rhs;
    logic [63:0] a2 [$];
    logic [63:0] d2 [$];
    pr = 0; dc = 0;
    bus2.c_address_valid     = 1'b1;
    bus2.c_address_input     = 64'h2000;
    bus2.matrix_length_input = 13'd4;
    bus2.mem_write_ready     = 1'b1;
    for (int k = 0; k < 60; k++) begin
      bus2.proc_valid = (pr < 4);
      for (int c = 0; c < 4; c++) bus2.proc_data[c] = 32'(pr*4+c);
      ahs = bus2.c_address_valid && bus2.c_address_ready;
      rhs = bus2.proc_valid && bus2.proc_ready;
      if (bus2.mem_write_valid) begin
        a2.push_back(bus2.mem_write_addr);
        d2.push_back({bus2.mem_write_data[1], bus2.mem_write_data[0]});
      end
      if (bus2.tile_done) dc++;
      @(posedge clk); #1;
      if (ahs) bus2.c_address_valid = 1'b0;
      if (rhs) pr++;
    end
    chk("p2_beats", 128'(a2.size()), 128'(8));
    for (int i = 0; i < 8; i++)
      chk("p2_addr", 128'((i < a2.size()) ? a2[i] : '1),
          128'(64'h2000 + 64'(i*8)));
    chk("p2_b1_data", 128'((d2.size() > 1) ? d2[1] : '1),
        128'({32'd3, 32'd2}));
    chk("p2_b7_data", 128'((d2.size() > 7) ? d2[7] : '1),
        128'({32'd15, 32'd14}));
    chk("p2_done", 128'(dc), 128'(1));
  endtask

  initial begin
    rst = 1'b1;
    bus.c_address_valid = 1'b0;
    bus.c_address_input = '0;
    bus.matrix_length_input = '0;
    bus.proc_valid = 1'b0;
    bus.mem_write_ready = 1'b1;
    for (int c = 0; c < 4; c++) bus.proc_data[c] = '0;
    bus2.c_address_valid = 1'b0;
    bus2.c_address_input = '0;
    bus2.matrix_length_input = '0;
    bus2.proc_valid = 1'b0;
    bus2.mem_write_ready = 1'b1;
    for (int c = 0; c < 4; c++) bus2.proc_data[c] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_c_rdy", 128'(bus.c_address_ready), 128'(1));
    chk("init_p_rdy", 128'(bus.proc_ready), 128'(0));
    chk("init_w_vld", 128'(bus.mem_write_valid), 128'(0));
    chk("init_addr", 128'(bus.mem_write_addr), 128'(0));
    chk("init_data", pk(), 128'(0));
    chk("init_done", 128'(bus.tile_done), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_tile(64'h1000, 13'd8, 1'b0, -1, 0, 64'h0, 0);
    chk("t1_beats", 128'(q_addr.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 128'(qa(i)), 128'(64'h1000 + 64'(i*32)));
      chk("t1_data", qd(i), exp_row(i));
    end
    chk("t1_done", 128'(done_cnt), 128'(1));
    chk("t1_lat", 128'(done_lat), 128'(9));

    run_tile(64'h1000, 13'd8, 1'b0, 2, 5, 64'h0, 0);
    chk("bp_beats", 128'(q_addr.size()), 128'(4));
    chk("bp_addr3", 128'(qa(3)), 128'(64'h1060));
    chk("bp_done", 128'(done_cnt), 128'(1));
    chk("bp_lat", 128'(done_lat), 128'(14));

    run_tile(64'h4000, 13'd8, 1'b0, -1, 0, 64'h9000, 0);
    chk("busy_addr0", 128'(qa(0)), 128'(64'h4000));
    chk("busy_addr3", 128'(qa(3)), 128'(64'h4060));
    chk("busy_done", 128'(done_cnt), 128'(1));
    run_tile(64'h0, 13'd0, 1'b1, -1, 0, 64'h0, 0);
    chk("nxt_beats", 128'(q_addr.size()), 128'(4));
    chk("nxt_addr0", 128'(qa(0)), 128'(64'h9000));
    chk("nxt_addr1", 128'(qa(1)), 128'(64'h9020));
    chk("nxt_done", 128'(done_cnt), 128'(1));

    run_tile(64'h5000, 13'd8, 1'b0, -1, 0, 64'h0, 2);
    chk("ab_beats", 128'(q_addr.size()), 128'(2));
    run_tile(64'h3000, 13'd8, 1'b0, -1, 0, 64'h0, 0);
    chk("rs_addr0", 128'(qa(0)), 128'(64'h3000));
    chk("rs_data0", qd(0), exp_row(0));
    chk("rs_addr3", 128'(qa(3)), 128'(64'h3060));
    chk("rs_done", 128'(done_cnt), 128'(1));

    run_tile(64'hFFFF_FFFF_FFFF_FFF0, 13'd4, 1'b0, -1, 0, 64'h0, 0);
    chk("wrap_a0", 128'(qa(0)), 128'(64'hFFFF_FFFF_FFFF_FFF0));
    chk("wrap_a1", 128'(qa(1)), 128'(64'h0));
    chk("wrap_a3", 128'(qa(3)), 128'(64'h20));

    run_tile(64'h7000, 13'd0, 1'b0, -1, 0, 64'h0, 0);
    for (int i = 0; i < 4; i++)
      chk("len0_addr", 128'(qa(i)), 128'(64'h7000));
    chk("len0_data3", qd(3), exp_row(3));

    run_p2();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
